// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//
// Purpose:
//   Small interrupt controller that arbitrates three sources (software MSIP,
//   timer level, external line) into a single request/cause pair for a core.
//   The external line is synchronised and, depending on EXT_EDGE, is either
//   latched on its rising edge into a sticky pending bit or used as a level.
//   A tiny register port lets software set MSIP, clear the external pending
//   bit and read back the source status.
//
// Parameters:
//   SWI_ADDR  word address of the MSIP register
//   EXT_ADDR  word address of the external status / clear register
//   EXT_EDGE  1 = external line is rising-edge latched, 0 = level
//
// Ports:
//   clk        single clock
//   resetb     asynchronous reset, active high (1 = in reset)
//   timer_irq  level interrupt from the timer, synchronous to clk
//   ext_irq    asynchronous external interrupt line
//   wready     write request valid this cycle
//   wvalid     tied to 1
//   waddr      write address
//   wdata      write data
//   wstrb      byte strobes (only byte 0 matters)
//   rready     read request valid this cycle
//   rvalid     tied to 1
//   raddr      read address
//   rresp      read data valid, one cycle after rready
//   rdata      read data
//   irq_req    interrupt request to the core
//   irq_cause  0 none, 1 software, 2 timer, 3 external
//   irq_ack    core accepts the current request
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter logic [31:0] SWI_ADDR = 32'h9000_0010,
  parameter logic [31:0] EXT_ADDR = 32'h9000_0014,
  parameter int          EXT_EDGE = 1
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        timer_irq,
  input  logic        ext_irq,
  input  logic        wready,
  output logic        wvalid,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        rready,
  output logic        rvalid,
  input  logic [31:0] raddr,
  output logic        rresp,
  output logic [31:0] rdata,
  output logic        irq_req,
  output logic [1:0]  irq_cause,
  input  logic        irq_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_SWI  = 2'd1;
  localparam logic [1:0] CAUSE_TMR  = 2'd2;
  localparam logic [1:0] CAUSE_EXT  = 2'd3;

  state_t      state_q;
  logic        irqReq_q;
  logic [1:0]  irqCause_q;

  logic        syncMeta_q;
  logic        extS_q;
  logic        extPrev_q;
  logic        extPend_q;
  logic        msip_q;
  logic        rresp_q;
  logic [31:0] rdata_q;

  logic        extPend_d;
  logic        msip_d;
  logic [31:0] rdata_d;

  logic        extPend;
  logic        extRise;
  logic        swiWrite;
  logic        extClrWrite;
  logic        ackExtClr;
  logic        causeActive;
  logic [1:0]  topCause;

  // Only bit 0 of the write data and strobe carry meaning in this block.
  logic        unusedBits;
  assign unusedBits = ^{wdata[31:1], wstrb[3:1]};

  assign wvalid    = 1'b1;
  assign rvalid    = 1'b1;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign irq_req   = irqReq_q;
  assign irq_cause = irqCause_q;

  // In level mode the synchronised line itself is the pending source.
  assign extPend     = (EXT_EDGE != 0) ? extPend_q : extS_q;
  assign extRise     = extS_q & ~extPrev_q;
  assign swiWrite    = wready && (waddr == SWI_ADDR) && wstrb[0];
  assign extClrWrite = wready && (waddr == EXT_ADDR) && wstrb[0] && wdata[0];
  // Accepting an external request consumes the latched edge.
  assign ackExtClr   = (state_q == REQ) && irq_ack && (irqCause_q == CAUSE_EXT);

  // Fixed priority: external beats software beats timer.
  always_comb begin
    topCause = CAUSE_NONE;
    if (extPend) begin
      topCause = CAUSE_EXT;
    end else if (msip_q) begin
      topCause = CAUSE_SWI;
    end else if (timer_irq) begin
      topCause = CAUSE_TMR;
    end
  end

  // Is the source that won arbitration still asserting?
  always_comb begin
    causeActive = 1'b0;
    case (irqCause_q)
      CAUSE_SWI: causeActive = msip_q;
      CAUSE_TMR: causeActive = timer_irq;
      CAUSE_EXT: causeActive = extPend;
      default:   causeActive = 1'b0;
    endcase
  end

  // Next state of the sticky external pending bit; a fresh edge always wins
  // over a software or acknowledge clear landing in the same cycle.
  always_comb begin
    extPend_d = extPend_q;
    if (EXT_EDGE != 0) begin
      if (extRise) begin
        extPend_d = 1'b1;
      end else if (extClrWrite || ackExtClr) begin
        extPend_d = 1'b0;
      end
    end else begin
      extPend_d = 1'b0;
    end
  end

  // MSIP and read-data next state; unmapped reads keep the old data.
  always_comb begin
    msip_d  = swiWrite ? wdata[0] : msip_q;
    rdata_d = rdata_q;
    if (rready) begin
      if (raddr == SWI_ADDR) begin
        rdata_d = {31'b0, msip_q};
      end else if (raddr == EXT_ADDR) begin
        rdata_d = {29'b0, timer_irq, extS_q, extPend};
      end
    end
  end

  // Synchroniser, edge history, software registers and read port.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      syncMeta_q <= 1'b0;
      extS_q     <= 1'b0;
      extPrev_q  <= 1'b0;
      extPend_q  <= 1'b0;
      msip_q     <= 1'b0;
      rresp_q    <= 1'b0;
      rdata_q    <= 32'b0;
    end else begin
      syncMeta_q <= ext_irq;
      extS_q     <= syncMeta_q;
      extPrev_q  <= extS_q;
      extPend_q  <= extPend_d;
      msip_q     <= msip_d;
      rresp_q    <= rready;
      rdata_q    <= rdata_d;
    end
  end

  // Request handshake FSM with registered request and cause outputs. The
  // cause is frozen on entry to REQ so the core sees a stable value.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q    <= IDLE;
      irqReq_q   <= 1'b0;
      irqCause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (topCause != CAUSE_NONE) begin
            state_q    <= REQ;
            irqReq_q   <= 1'b1;
            irqCause_q <= topCause;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q    <= HOLD;
            irqReq_q   <= 1'b0;
            irqCause_q <= CAUSE_NONE;
          end else if (!causeActive) begin
            state_q    <= IDLE;
            irqReq_q   <= 1'b0;
            irqCause_q <= CAUSE_NONE;
          end
        end
        HOLD: begin
          state_q    <= IDLE;
          irqReq_q   <= 1'b0;
          irqCause_q <= CAUSE_NONE;
        end
        default: begin
          state_q    <= IDLE;
          irqReq_q   <= 1'b0;
          irqCause_q <= CAUSE_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SWI_ADDR, 32'h9000_0010, software-interrupt (MSIP) register word address.
- EXT_ADDR, 32'h9000_0014, external-interrupt status/clear register word address.
- EXT_EDGE, 1, 1 = ext_irq rising-edge latched; 0 = ext_irq level.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- resetb  in  1  asynchronous, active-high reset; asserted (1) = reset.
- timer_irq  in  1  level interrupt from timer block, synchronous to clk.
- ext_irq  in  1  asynchronous external interrupt line.
- wready  in  1  write request valid this cycle.
- wvalid  out  1  constant 1.
- waddr  in  32  write address.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- rready  in  1  read request valid this cycle.
- rvalid  out  1  constant 1.
- raddr  in  32  read address.
- rresp  out  1  read data valid, one cycle after rready.
- rdata  out  32  read data.
- irq_req  out  1  interrupt request to core.
- irq_cause  out  2  0 none, 1 software, 2 timer, 3 external.
- irq_ack  in  1  core accepts the current request.

Function
REQ-003 ext_irq SHALL pass through a 2-flop synchronizer (ext_s); ext_s lags ext_irq by 2 clk edges.
REQ-004 EXT_EDGE=1: a 0->1 transition of ext_s SHALL set ext_pend on the next edge; EXT_EDGE=0: ext_pend SHALL equal ext_s.
REQ-005 Write with wready=1, waddr=SWI_ADDR, wstrb[0]=1 SHALL load msip <= wdata[0]; wstrb[0]=0 SHALL leave msip unchanged.
REQ-006 Write with wready=1, waddr=EXT_ADDR, wstrb[0]=1, wdata[0]=1 SHALL clear ext_pend (edge mode only); set and clear in the same cycle: set SHALL win.
REQ-007 Writes to other addresses SHALL be ignored.
REQ-008 rresp SHALL be rready registered by one cycle.
REQ-009 On rready, rdata SHALL load {31'b0, msip} for SWI_ADDR, {29'b0, timer_irq, ext_s, ext_pend} for EXT_ADDR, else hold its value.
REQ-010 Source priority SHALL be external > software > timer; active sources: ext_pend, msip, timer_irq.
REQ-011 FSM states SHALL be IDLE, REQ, HOLD.
REQ-012 IDLE: if any source active, go to REQ next edge with irq_cause latched to highest-priority source; irq_req=0, irq_cause=0 in IDLE.
REQ-013 REQ: irq_req=1, irq_cause stable at latched value regardless of lower or higher sources arriving.
REQ-014 REQ with irq_ack=1: go to HOLD; if cause=3 and EXT_EDGE=1, clear ext_pend on that edge (a new edge in the same cycle SHALL re-set it).
REQ-015 REQ with latched source inactive and irq_ack=0: withdraw, return to IDLE, irq_req=0 next cycle.
REQ-016 HOLD: irq_req=0, irq_cause=0 for exactly one cycle, then IDLE; new requests SHALL be re-arbitrated in IDLE.
REQ-017 irq_ack outside REQ SHALL be ignored.
REQ-018 Level sources (msip, timer_irq, level ext) SHALL be cleared only at their origin; the block never clears them.

Reset
REQ-019 While resetb=1: msip=0, ext_pend=0, synchronizer flops=0, edge-detect history=0, FSM=IDLE, irq_req=0, irq_cause=0, rresp=0, rdata=0.
REQ-020 Reset asserted mid-REQ SHALL drop irq_req asynchronously; after release, a still-active level source SHALL request again from IDLE.
REQ-021 Release: first FSM transition SHALL occur on the first clk edge with resetb=0.

Verification
REQ-022 Write SWI_ADDR wdata=1 wstrb=4'h1 -> irq_req=1, irq_cause=1 two cycles later; ack -> HOLD one cycle; msip still 1 -> request again.
REQ-023 timer_irq=1 and msip=1 simultaneously in IDLE -> irq_cause=1; clear msip and ack -> next request irq_cause=2.
REQ-024 EXT_EDGE=1, pulse ext_irq 0->1 -> ext_pend=1 after 3 edges, irq_cause=3; ack -> ext_pend=0, no re-request while ext_irq stays high.
REQ-025 In REQ with cause=1, write msip=0 before ack -> irq_req=0 next cycle, FSM IDLE.
REQ-026 Read EXT_ADDR with ext_pend=1, timer_irq=1 -> rresp=1 and rdata=32'h0000_0005 next cycle (ext_s=0); read unmapped address -> rdata unchanged.
REQ-027 Assert resetb during REQ -> irq_req=0 immediately, all registers at REQ-019 values.
